// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Shared types and constants for the pipeline MEM stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC2 = 2'b10;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int CNT_W           = 8;

    // A store, or any instruction that writes back memory read data, needs the bus.
    function automatic logic is_mem_op(input logic mem_write, input logic [1:0] result_src);
        return mem_write || (result_src == RES_MEM);
    endfunction

    // Write-back data for instructions that never touch the bus; 11 aliases the ALU path.
    function automatic logic [15:0] pass_result(input logic [1:0]  result_src,
                                                input logic [15:0] alu_res,
                                                input logic [15:0] pc_plus2);
        return (result_src == RES_PC2) ? pc_plus2 : alu_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_unit.sv
// ============================================================================
// Module : mem_stage_unit
// Brief  : MEM pipeline stage with a request/ack data bus, stall and timeout abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWrite_in,
    input  logic        memWrite_in,
    input  logic [1:0]  resultSrc_in,
    input  logic [15:0] pc_plus2_in,
    input  logic [3:0]  rd_in,
    input  logic [15:0] aluRes_in,
    input  logic [15:0] op2_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_out,
    output logic        wb_valid,
    output logic        regWrite_out,
    output logic [3:0]  rd_out,
    output logic [15:0] result_out,
    output logic        err_out
);

    localparam logic [CNT_W-1:0] c_last_wait = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cap_regwrite;
    logic [3:0]       r_cap_rd;

    logic w_is_mem;
    logic w_expired;

    assign w_is_mem  = is_mem_op(memWrite_in, resultSrc_in);
    assign w_expired = (r_cnt == c_last_wait);

    // Freeze upstream until the bus cycle resolves; the abort cycle releases it.
    always_comb begin
        stall_out = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: stall_out = w_is_mem;
                ST_WAIT: stall_out = !mem_ack && !w_expired;
                default: stall_out = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_cap_regwrite <= 1'b0;
            r_cap_rd       <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            wb_valid       <= 1'b0;
            regWrite_out   <= 1'b0;
            rd_out         <= '0;
            result_out     <= '0;
            err_out        <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            regWrite_out <= 1'b0;
            err_out      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        r_state        <= ST_WAIT;
                        r_cnt          <= '0;
                        r_cap_regwrite <= regWrite_in;
                        r_cap_rd       <= rd_in;
                        mem_req        <= 1'b1;
                        mem_we         <= memWrite_in;
                        mem_addr       <= aluRes_in;
                        mem_wdata      <= op2_in;
                    end else begin
                        wb_valid     <= 1'b1;
                        regWrite_out <= regWrite_in;
                        rd_out       <= rd_in;
                        result_out   <= pass_result(resultSrc_in, aluRes_in, pc_plus2_in);
                    end
                end

                ST_WAIT: begin
                    // Ack takes priority over an expiry in the same cycle.
                    if (mem_ack) begin
                        r_state      <= ST_IDLE;
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        regWrite_out <= r_cap_regwrite;
                        rd_out       <= r_cap_rd;
                        result_out   <= mem_we ? mem_addr : mem_rdata;
                    end else if (w_expired) begin
                        r_state  <= ST_IDLE;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        err_out  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
// ============================================================================
// Module : tb_mem_stage_unit
// Brief  : Directed plus randomized self-checking bench for mem_stage_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_unit;

    localparam int c_timeout = 4;

    logic        clk;
    logic        reset;
    logic        regWrite_in;
    logic        memWrite_in;
    logic [1:0]  resultSrc_in;
    logic [15:0] pc_plus2_in;
    logic [3:0]  rd_in;
    logic [15:0] aluRes_in;
    logic [15:0] op2_in;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall_out;
    logic        wb_valid;
    logic        regWrite_out;
    logic [3:0]  rd_out;
    logic [15:0] result_out;
    logic        err_out;

    mem_stage_unit #(.TIMEOUT(c_timeout)) dut (
        .clk          (clk),
        .reset        (reset),
        .regWrite_in  (regWrite_in),
        .memWrite_in  (memWrite_in),
        .resultSrc_in (resultSrc_in),
        .pc_plus2_in  (pc_plus2_in),
        .rd_in        (rd_in),
        .aluRes_in    (aluRes_in),
        .op2_in       (op2_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall_out    (stall_out),
        .wb_valid     (wb_valid),
        .regWrite_out (regWrite_out),
        .rd_out       (rd_out),
        .result_out   (result_out),
        .err_out      (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an outstanding bus transaction plus the number of cycles it has waited.
    bit          m_busy;
    bit          m_we;
    bit          m_rw;
    logic [3:0]  m_rd;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    int          m_waited;
    bit          e_req, e_we, e_wb, e_rw, e_err, e_res_known;
    logic [3:0]  e_rd;
    logic [15:0] e_res, e_addr, e_wdata;

    function automatic bit wants_bus();
        return memWrite_in || (resultSrc_in == 2'b01);
    endfunction

    function automatic bit expect_stall();
        if (reset) return 1'b0;
        if (!m_busy) return wants_bus();
        return !mem_ack && (m_waited + 1 != c_timeout);
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_busy = 0; e_req = 0; e_we = 0; e_wb = 0; e_rw = 0; e_err = 0;
            e_rd = 0; e_res = 0; e_addr = 0; e_wdata = 0; e_res_known = 1;
            return;
        end
        e_wb = 0; e_rw = 0; e_err = 0;
        if (!m_busy) begin
            if (wants_bus()) begin
                m_busy = 1; m_waited = 0;
                m_we = memWrite_in; m_rw = regWrite_in; m_rd = rd_in;
                m_addr = aluRes_in; m_wdata = op2_in;
                e_req = 1; e_we = memWrite_in; e_addr = aluRes_in; e_wdata = op2_in;
            end else begin
                e_wb = 1; e_rw = regWrite_in; e_rd = rd_in; e_res_known = 1;
                e_res = (resultSrc_in == 2'b10) ? pc_plus2_in : aluRes_in;
            end
        end else if (mem_ack) begin
            m_busy = 0; e_req = 0;
            e_wb = 1; e_rw = m_rw; e_rd = m_rd; e_res_known = 1;
            e_res = m_we ? m_addr : mem_rdata;
        end else if (m_waited + 1 == c_timeout) begin
            m_busy = 0; e_req = 0; e_wb = 1; e_err = 1; e_res_known = 0;
        end else begin
            m_waited++;
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle();
        #1;
        check_eq("stall_out", stall_out, expect_stall());
        @(posedge clk);
        model_edge();
        #1;
        check_eq("wb_valid", wb_valid, e_wb);
        check_eq("regWrite_out", regWrite_out, e_rw);
        check_eq("err_out", err_out, e_err);
        check_eq("mem_req", mem_req, e_req);
        if (e_res_known) begin
            check_eq("rd_out", rd_out, e_rd);
            check_eq("result_out", result_out, e_res);
        end
        if (e_req) begin
            check_eq("mem_we", mem_we, e_we);
            check_eq("mem_addr", mem_addr, e_addr);
            check_eq("mem_wdata", mem_wdata, e_wdata);
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit rw, input bit mw, input logic [1:0] src,
                          input logic [15:0] pc2, input logic [3:0] rd,
                          input logic [15:0] alu, input logic [15:0] op2);
        regWrite_in = rw; memWrite_in = mw; resultSrc_in = src;
        pc_plus2_in = pc2; rd_in = rd; aluRes_in = alu; op2_in = op2;
    endtask

    task automatic nop();
        set_in(0, 0, 2'b00, 16'h0, 4'h0, 16'h0, 16'h0);
    endtask

    initial begin
        reset = 1; mem_ack = 0; mem_rdata = 16'h0;
        nop();
        m_busy = 0; m_waited = 0; e_res_known = 1;
        @(negedge clk);
        cycle();
        cycle();
        reset = 0;

        // Pass-through returning PC+2
        set_in(1, 0, 2'b10, 16'h0102, 4'd3, 16'h7777, 16'h0);
        cycle();
        nop();
        cycle();

        // Load acknowledged in the third wait cycle
        set_in(1, 0, 2'b01, 16'h0, 4'd5, 16'h0040, 16'h0);
        cycle();
        nop();
        cycle();
        cycle();
        mem_ack = 1; mem_rdata = 16'hBEEF;
        cycle();
        mem_ack = 0; mem_rdata = 16'h0;
        cycle();

        // Store with immediate ack
        set_in(0, 1, 2'b00, 16'h0, 4'd7, 16'h0010, 16'h1234);
        cycle();
        nop();
        mem_ack = 1;
        cycle();
        mem_ack = 0;
        cycle();

        // Load that times out
        set_in(1, 0, 2'b01, 16'h0, 4'd9, 16'h0080, 16'h0);
        cycle();
        nop();
        for (int i = 0; i < c_timeout; i++) cycle();
        cycle();

        // Ack arriving in the expiry cycle
        set_in(1, 0, 2'b01, 16'h0, 4'd2, 16'h00A0, 16'h0);
        cycle();
        nop();
        for (int i = 0; i < c_timeout - 1; i++) cycle();
        mem_ack = 1; mem_rdata = 16'h5A5A;
        cycle();
        mem_ack = 0;
        cycle();

        // Reset while waiting
        set_in(1, 1, 2'b01, 16'h0, 4'd4, 16'h00C0, 16'h4321);
        cycle();
        nop();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        cycle();

        // Randomized traffic, including acks while idle and occasional resets
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                   2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom),
                   16'($urandom), 16'($urandom));
            mem_ack   = ($urandom_range(0, 9) < 3);
            mem_rdata = 16'($urandom);
            reset     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 0; mem_ack = 0;
        nop();
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_unit.md
MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum WAIT cycles before a bus access is aborted (legal range 1..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 regWrite_in  input  1  register-write enable from the EXE/MEM register.
REQ-005 memWrite_in  input  1  store enable from the EXE/MEM register.
REQ-006 resultSrc_in  input  2  result select: 00 ALU, 01 memory read data, 10 PC+2, 11 reserved (treated as 00).
REQ-007 pc_plus2_in  input  16  PC+2 of the instruction.
REQ-008 rd_in  input  4  destination register.
REQ-009 aluRes_in  input  16  ALU result, also the memory byte address.
REQ-010 op2_in  input  16  store data.
REQ-011 mem_req  output  1  bus request, held until ack or abort.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-013 mem_addr  output  16  captured aluRes_in; valid while mem_req.
REQ-014 mem_wdata  output  16  captured op2_in; valid while mem_req.
REQ-015 mem_rdata  input  16  read data; sampled only in the ack cycle.
REQ-016 mem_ack  input  1  single-cycle completion strobe from data memory.
REQ-017 stall_out  output  1  freeze IF..EXE/MEM registers (combinational).
REQ-018 wb_valid  output  1  MEM/WB outputs hold a retired instruction this cycle.
REQ-019 regWrite_out  output  1  write-back enable to the register file.
REQ-020 rd_out  output  4  write-back destination.
REQ-021 result_out  output  16  write-back data.
REQ-022 err_out  output  1  one-cycle pulse on a bus timeout abort.

Function
REQ-023 A memory op is memWrite_in=1 or resultSrc_in=01; any other input is a pass-through op.
REQ-024 FSM states: IDLE, WAIT.
REQ-025 IDLE, pass-through op: on the next edge, wb_valid=1, regWrite_out=regWrite_in, rd_out=rd_in, result_out=aluRes_in (00/11) or pc_plus2_in (10); latency 1 cycle.
REQ-026 IDLE, memory op: stall_out=1 in that cycle; on the edge, capture all inputs, go to WAIT, assert mem_req with mem_we=memWrite_in, load the timeout counter with 0, and drive wb_valid=0.
REQ-027 WAIT: inputs are ignored; stall_out = NOT mem_ack; the counter increments each cycle without ack.
REQ-028 WAIT with mem_ack=1: on the edge, drop mem_req, return to IDLE, wb_valid=1, regWrite_out=captured regWrite, rd_out=captured rd, result_out=mem_rdata for a read or captured aluRes for a write.
REQ-029 WAIT, counter reaches TIMEOUT-1 with no ack: on the edge, drop mem_req, return to IDLE, err_out=1, wb_valid=1, regWrite_out=0; stall_out=0 in that cycle.
REQ-030 If ack and timeout occur in the same cycle, ack wins: normal completion, err_out=0.
REQ-031 mem_ack in IDLE is ignored.
REQ-032 Back-to-back memory ops are legal: the IDLE cycle after a completion accepts the next op with no bubble beyond REQ-026.
REQ-033 wb_valid, regWrite_out and err_out are 0 in every cycle not covered by REQ-025/028/029; rd_out and result_out hold their last value.
REQ-034 stall_out never asserts in a pass-through IDLE cycle.

Reset
REQ-035 reset=1 at an edge forces IDLE; mem_req, mem_we, wb_valid, regWrite_out and err_out go to 0; rd_out, result_out, mem_addr, mem_wdata and the counter go to 0.
REQ-036 Reset during WAIT abandons the access: mem_req is 0 from the next cycle, with no err_out pulse.
REQ-037 While reset=1, stall_out=0.

Structure
REQ-038 Shared package mem_stage_pkg holds: state enum (IDLE, WAIT); the resultSrc encodings RES_ALU=00, RES_MEM=01, RES_PC2=10; and the default TIMEOUT.
REQ-039 The block is a single module with no sub-module; the counter width is 8 bits.

Verification
REQ-040 Pass-through: resultSrc=10, pc_plus2=0x0102, rd=3, regWrite=1 -> next cycle wb_valid=1, rd_out=3, result_out=0x0102, stall_out never 1.
REQ-041 Load: aluRes=0x0040, resultSrc=01, rd=5, ack 3 cycles after mem_req with rdata=0xBEEF -> mem_addr=0x0040, mem_we=0, stall held until the ack cycle, then result_out=0xBEEF, regWrite_out=1, rd_out=5.
REQ-042 Store: memWrite=1, aluRes=0x0010, op2=0x1234, immediate ack -> mem_we=1, mem_wdata=0x1234, one stall cycle plus the ack cycle, wb_valid=1.
REQ-043 Timeout: TIMEOUT=4, load with no ack -> mem_req high 4 cycles, then err_out=1 for one cycle, regWrite_out=0, FSM in IDLE.
REQ-044 Race and reset: ack in the timeout cycle -> normal completion with err_out=0; reset asserted mid-WAIT -> mem_req=0 next cycle, no wb_valid and no err_out.
